alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Initiator side for the team's combinational ALU (16-bit A/B, carry-in C, 3-bit opcode; outputs W, zero, negative).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives one operation at a time onto registered ALU operand ports, waits a fixed settle time, then captures the result.
- Returns the result over a valid/ready response interface. It sits between a command source (bench, controller) and an external ALU instance.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- SETTLE_CYCLES, 1, cycles operands are held before capture; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- cmd_c  in  1  carry-in.
- cmd_opcode  in  3  ALU opcode.
- alu_a  out  16  registered operand A to the ALU.
- alu_b  out  16  registered operand B to the ALU.
- alu_c  out  1  registered carry-in to the ALU.
- alu_opcode  out  3  registered opcode to the ALU.
- alu_w  in  16  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_negative  in  1  ALU negative flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_w  out  16  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_negative  out  1  captured negative flag.
- rsp_opcode  out  3  opcode of the captured op.
- busy  out  1  state != IDLE or FIFO non-empty.
- done_count  out  16  completed response handshakes, wraps 0xFFFF→0.

Behaviour:
- Reset (async on rst_n low, immediate): every output register is 0, the FIFO is emptied, state is IDLE. Consequently cmd_ready=1 and busy=0. Reset mid-operation discards the in-flight op and all queued ops, with no partial response.
- Push: on a clock edge with cmd_valid && cmd_ready. cmd_ready = !full, combinational from the FIFO count.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle (no pass-through).
  - Push and pop in the same cycle are legal when not full; the count is unchanged.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE: if the FIFO is non-empty, pop at the edge, load alu_* from the head entry, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
  - SETTLE: decrement the counter. At the edge where the counter is 0, capture alu_w, alu_zero, alu_negative and the current alu_opcode into rsp_*, set rsp_valid=1, and go to RESP.
  - RESP: rsp_* and rsp_valid are held stable until rsp_valid && rsp_ready.
  - On that handshake: clear rsp_valid and increment done_count. If the FIFO is non-empty, pop and load alu_* in the same edge and go to SETTLE (back-to-back); otherwise go to IDLE.
- Latency: an accepted command reaches an empty, idle block at edge T. alu_* update at T+1 and rsp_valid rises at T+1+SETTLE_CYCLES.
- Throughput: with rsp_ready held at 1, one response every SETTLE_CYCLES+1 cycles.
- alu_* keep their last value when idle (not cleared). Only one op is ever in flight. Responses are returned strictly in command order.
- done_count changes only on a response handshake.

Decomposition:
- Package alu_seq_pkg:
  - DATA_W=16, OPC_W=3;
  - state_t enum {IDLE, SETTLE, RESP};
  - cmd_t packed struct {a, b, c, opcode}.
- One sub-module, alu_cmd_fifo: synchronous FIFO of cmd_t.
  - Parameter DEPTH.
  - Async active-low reset.
  - Ports push, pop, full, empty, head.
- The ALU itself is external, not instantiated here.

Test Plan:
All scenarios use a bench stub ALU with W=A^B, zero=(W==0), negative=W[15], SETTLE_CYCLES=1, DEPTH=4.
1. Reset: hold rst_n=0 → all outputs 0, cmd_ready=1, busy=0. Assert rst_n=0 between edges → outputs clear without waiting for a clock.
2. Single op: accept A=0x00F0, B=0x0F00, C=0, opcode=3 at edge T → alu_a=0x00F0 and alu_opcode=3 at T+1. At T+2: rsp_valid=1, rsp_w=0x0FF0, zero=0, negative=0, rsp_opcode=3. After the handshake, done_count=1.
3. Fill: rsp_ready=0, cmd_valid=1 every cycle with 6 distinct commands → exactly 5 accepted (1 in flight + 4 queued), cmd_ready=0 on the 6th, busy=1.
4. Backpressure and drain: continue from scenario 3 and hold rsp_ready=0 for 10 cycles → rsp_* stable. Then rsp_ready=1 → 5 responses in order, spaced 2 cycles apart, done_count=5, then IDLE with busy=0.
5. Flags: A=B=0x1234 → rsp_w=0x0000, zero=1. A=0x8000, B=0x0000 → rsp_w=0x8000, negative=1, zero=0.
6. Reset mid-op: in RESP with 2 commands queued, pulse rst_n low → rsp_valid=0 immediately, queue empty, done_count=0. A new command afterwards completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer.
// Command bundle layout and FSM state encoding.
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              c;
        logic [OPC_W-1:0]  opcode;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO feeding the sequencer.
// Head is read combinationally from the storage array.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output logic full,
    output logic empty,
    output cmd_t head
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives one op at a time onto the
// registered ALU operands, and returns results in order.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_c,
    input  logic [2:0]  cmd_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_c,
    output logic [2:0]  alu_opcode,
    input  logic [15:0] alu_w,
    input  logic        alu_zero,
    input  logic        alu_negative,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_w,
    output logic        rsp_zero,
    output logic        rsp_negative,
    output logic [2:0]  rsp_opcode,
    output logic        busy,
    output logic [15:0] done_count
);

    localparam int CW =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            pop;
    logic            capture;
    logic            hs;
    logic            full;
    logic            empty;
    logic            push;
    cmd_t            din;
    cmd_t            head;

    assign din       = {cmd_a, cmd_b, cmd_c, cmd_opcode};
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        hs        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    hs = 1'b1;
                    // Back-to-back issue skips IDLE.
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_c        <= 1'b0;
            alu_opcode   <= '0;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_w        <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_opcode   <= '0;
            done_count   <= '0;
        end else begin
            if (pop) begin
                alu_a      <= head.a;
                alu_b      <= head.b;
                alu_c      <= head.c;
                alu_opcode <= head.opcode;
                cnt        <= CW'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                rsp_valid    <= 1'b1;
                rsp_w        <= alu_w;
                rsp_zero     <= alu_zero;
                rsp_negative <= alu_negative;
                rsp_opcode   <= alu_opcode;
            end else if (hs) begin
                rsp_valid <= 1'b0;
            end
            if (hs)
                done_count <= done_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with an XOR stub ALU,
// directed vectors, corner sequences and a queue model.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_c;
    logic [2:0]  cmd_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_c;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_w;
    logic        alu_zero;
    logic        alu_negative;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_w;
    logic        rsp_zero;
    logic        rsp_negative;
    logic [2:0]  rsp_opcode;
    logic        busy;
    logic [15:0] done_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign alu_w        = alu_a ^ alu_b;
    assign alu_zero     = (alu_w == 16'h0000);
    assign alu_negative = alu_w[15];

    alu_op_sequencer #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_c        (cmd_c),
        .cmd_opcode   (cmd_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_c        (alu_c),
        .alu_opcode   (alu_opcode),
        .alu_w        (alu_w),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_w        (rsp_w),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
        .rsp_opcode   (rsp_opcode),
        .busy         (busy),
        .done_count   (done_count)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [2:0]  opc;
        logic [15:0] w;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vt [5];

    // Reference model: queue of waiting commands, one op in
    // flight with a settle timer, one presented response.
    cmd_t        m_q [$];
    cmd_t        m_cur;
    bit          m_fl;
    int          m_t;
    bit          m_rv;
    logic [15:0] m_rw;
    logic [2:0]  m_ropc;
    logic [15:0] m_done;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur  = '0;
        m_fl   = 0;
        m_t    = 0;
        m_rv   = 0;
        m_rw   = '0;
        m_ropc = '0;
        m_done = '0;
    endtask

    task automatic model_check();
        check("m_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
        check("m_busy", 32'(busy),
              32'(m_fl || m_rv || m_q.size() > 0));
        check("m_rvalid", 32'(rsp_valid), 32'(m_rv));
        check("m_done", 32'(done_count), 32'(m_done));
        check("m_alu_a", 32'(alu_a), 32'(m_cur.a));
        check("m_alu_opc", 32'(alu_opcode), 32'(m_cur.opcode));
        if (m_rv) begin
            check("m_rw", 32'(rsp_w), 32'(m_rw));
            check("m_ropc", 32'(rsp_opcode), 32'(m_ropc));
            check("m_rzero", 32'(rsp_zero), 32'(m_rw == 16'h0));
            check("m_rneg", 32'(rsp_negative), 32'(m_rw[15]));
        end
    endtask

    task automatic model_step();
        bit   push;
        cmd_t nc;
        push = cmd_valid && (m_q.size() < DEPTH);
        nc   = {cmd_a, cmd_b, cmd_c, cmd_opcode};
        if (m_rv && rsp_ready) begin
            m_rv   = 0;
            m_done = m_done + 16'd1;
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_fl  = 1;
                m_t   = SETTLE;
            end
        end else if (m_fl) begin
            m_t--;
            if (m_t == 0) begin
                m_fl   = 0;
                m_rv   = 1;
                m_rw   = m_cur.a ^ m_cur.b;
                m_ropc = m_cur.opcode;
            end
        end else if (!m_rv && m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_fl  = 1;
            m_t   = SETTLE;
        end
        if (push)
            m_q.push_back(nc);
    endtask

    task automatic drive_cmd(input logic [15:0] a,
                             input logic [15:0] b,
                             input logic        c,
                             input logic [2:0]  opc);
        cmd_valid  = 1'b1;
        cmd_a      = a;
        cmd_b      = b;
        cmd_c      = c;
        cmd_opcode = opc;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rsp_valid), 32'd1);
    endtask

    logic [15:0] fa [6];
    logic [15:0] fb [6];

    initial begin
        int idx;
        int acc;
        int k;
        int last;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_c      = 1'b0;
        cmd_opcode = '0;
        rsp_ready  = 1'b0;

        vt[0] = '{16'h00F0, 16'h0F00, 1'b0, 3'd3,
                  16'h0FF0, 1'b0, 1'b0};
        vt[1] = '{16'h1234, 16'h1234, 1'b1, 3'd5,
                  16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h8000, 16'h0000, 1'b0, 3'd7,
                  16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'hFFFF, 16'h0001, 1'b1, 3'd0,
                  16'hFFFE, 1'b0, 1'b1};
        vt[4] = '{16'hA5A5, 16'h5A5A, 1'b0, 3'd1,
                  16'hFFFF, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            fa[i] = 16'(16'h0100 * (i + 1));
            fb[i] = 16'(16'h0011 * (i + 3));
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_co", 32'({alu_c, alu_opcode}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_w, rsp_zero,
              rsp_negative, rsp_opcode}), 32'd0);
        check("rst_done", 32'(done_count), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with latency checks
        for (int i = 0; i < 5; i++) begin
            drive_cmd(vt[i].a, vt[i].b, vt[i].c, vt[i].opc);
            @(negedge clk);
            cmd_valid = 1'b0;
            check("vec_early", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("vec_alu_a", 32'(alu_a), 32'(vt[i].a));
            check("vec_alu_opc", 32'(alu_opcode), 32'(vt[i].opc));
            check("vec_notyet", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("vec_valid", 32'(rsp_valid), 32'd1);
            check("vec_w", 32'(rsp_w), 32'(vt[i].w));
            check("vec_zero", 32'(rsp_zero), 32'(vt[i].z));
            check("vec_neg", 32'(rsp_negative), 32'(vt[i].n));
            check("vec_opc", 32'(rsp_opcode), 32'(vt[i].opc));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("vec_done", 32'(done_count), 32'(i + 1));
            check("vec_clr", 32'(rsp_valid), 32'd0);
            check("vec_idle", 32'(busy), 32'd0);
        end

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_alu_a", 32'(alu_a), 32'd0);
        check("arst_done", 32'(done_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill: one in flight plus DEPTH queued
        idx = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            drive_cmd(fa[idx], fb[idx], 1'b0, 3'(idx + 1));
            if (cmd_ready) begin
                acc++;
                if (idx < 5)
                    idx++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("fill_acc", 32'(acc), 32'd5);
        check("fill_ready", 32'(cmd_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);

        // Backpressure holds the response
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_w", 32'(rsp_w), 32'(fa[0] ^ fb[0]));
            check("hold_opc", 32'(rsp_opcode), 32'd1);
            @(negedge clk);
        end

        // Drain in order, one response every two cycles
        rsp_ready = 1'b1;
        k = 0;
        last = 0;
        for (int c = 0; c < 30 && k < 5; c++) begin
            if (rsp_valid) begin
                check("drain_w", 32'(rsp_w), 32'(fa[k] ^ fb[k]));
                check("drain_opc", 32'(rsp_opcode), 32'(k + 1));
                if (k > 0)
                    check("drain_gap", 32'(c - last), 32'd2);
                last = c;
                k++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        check("drain_cnt", 32'(k), 32'd5);
        check("drain_done", 32'(done_count), 32'd5);
        check("drain_busy", 32'(busy), 32'd0);

        // Reset while a response is pending and two are queued
        for (int i = 0; i < 3; i++) begin
            drive_cmd(fa[i], fb[i], 1'b1, 3'(i));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_rsp("mid_wait");
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rvalid", 32'(rsp_valid), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_ready", 32'(cmd_ready), 32'd1);
        check("mid_done", 32'(done_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_empty", 32'({busy, rsp_valid}), 32'd0);
        drive_cmd(16'h0F0F, 16'h00FF, 1'b0, 3'd6);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("post_wait");
        check("post_w", 32'(rsp_w), 32'h0FF0);
        check("post_opc", 32'(rsp_opcode), 32'd6);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_done", 32'(done_count), 32'd1);

        // Randomized traffic against the queue model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            cmd_valid  = ($urandom_range(0, 9) < 7);
            cmd_a      = 16'($urandom);
            cmd_b      = ($urandom_range(0, 7) == 0)
                         ? cmd_a : 16'($urandom);
            cmd_c      = 1'($urandom);
            cmd_opcode = 3'($urandom);
            rsp_ready  = ($urandom_range(0, 1) == 1);
            model_check();
            model_step();
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
